ro_puf_evaluator: RTL

Parametrised ring-oscillator PUF evaluator, successor to the fixed four-RO, two-bit cell. Drives the enable of NUM_RO external RO channels and counts each channel's rising edges over a programmable window. A challenge selects RO pairs, and the block emits one response bit per pair (count A > count B) plus tie/invalid flags. Sits between the RO array and the challenge/response host interface.

---
 rtl/ro_puf_pkg.sv | 26 ++
 rtl/ro_puf_evaluator_if.sv | 28 ++
 rtl/ro_edge_counter.sv | 33 +++
 rtl/ro_puf_evaluator.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the ring-oscillator PUF evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    COUNT   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Bits needed to address one RO channel; never less than one.
  function automatic int idx_w(input int num_ro);
    return (num_ro <= 2) ? 1 : $clog2(num_ro);
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter (w < 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/ro_puf_evaluator_if.sv
// Challenge/response host bundle of the RO PUF evaluator.
// Latency: n/a (wires only).
// Backpressure: none; start is a single-cycle request, dropped by the slave while busy.
// Ports: start/challenge/window_len from host; busy/done/response/tie/invalid to host.
interface ro_puf_evaluator_if
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO    = 4,
  parameter int RESP_BITS = 2,
  parameter int WIN_W     = 16
);
  localparam int IDX_W = idx_w(NUM_RO);
  localparam int CH_W  = RESP_BITS * 2 * IDX_W;

  logic                 start;
  logic [CH_W-1:0]      challenge;
  logic [WIN_W-1:0]     window_len;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;
  logic [RESP_BITS-1:0] tie;
  logic [RESP_BITS-1:0] invalid;

  modport master (output start, challenge, window_len,
                  input  busy, done, response, tie, invalid);
  modport slave  (input  start, challenge, window_len,
                  output busy, done, response, tie, invalid);
endinterface

// File: rtl/ro_edge_counter.sv
// One RO channel: 2-FF synchroniser, rising-edge detect, saturating edge counter.
// Latency: an ro_in rising edge reaches the counter 3 clk later.
// Backpressure: none; counts only while cnt_en, clr wins over counting.
// Ports: clk, rst_n, ro_in (async), clr, cnt_en -> cnt.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt
);
  // sync_q[0], sync_q[1] form the synchroniser; sync_q[2] is the edge-detect history.
  logic [2:0] sync_q;
  logic       rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], ro_in};
  end

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (cnt_en && rise)  cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
  end
endmodule

// File: rtl/ro_puf_evaluator.sv
// RO PUF evaluator: enables the RO array, counts edges over a window, compares challenge pairs.
// Latency: start to done = 1 + SETTLE_CYC + max(window_len,1) + RESP_BITS cycles.
// Backpressure: start is ignored while busy; nothing is queued.
// Ports: clk, rst_n, host (slave modport of ro_puf_evaluator_if), ro_in -> ro_en.
module ro_puf_evaluator
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO     = 4,
  parameter int RESP_BITS  = 2,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  ro_puf_evaluator_if.slave  host,
  input  logic [NUM_RO-1:0]  ro_in,
  output logic [NUM_RO-1:0]  ro_en
);
  localparam int IDX_W = idx_w(NUM_RO);
  localparam int CH_W  = RESP_BITS * 2 * IDX_W;
  localparam int NSLOT = 1 << IDX_W;
  localparam int PI_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  // Reset asserts asynchronously but is released in step with clk.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  state_t               state, state_nxt;
  logic [WIN_W-1:0]     tmr, win_q;
  logic [CH_W-1:0]      ch_q;
  logic                 accept, cnt_en, cmp_en, busy_o, done_o;
  logic                 last_settle, last_count, last_pair;
  logic [CNT_W-1:0]     cnt_all [NSLOT];
  logic [PI_W-1:0]      pidx;
  logic [IDX_W-1:0]     idx_a, idx_b;
  logic                 pair_inv;
  logic [RESP_BITS-1:0] resp_q, tie_q, inv_q;

  // tmr counts cycles spent in the current state (window, settle, or pair index).
  assign last_settle = (tmr == WIN_W'(SETTLE_CYC - 1));
  assign last_count  = (tmr == win_q - WIN_W'(1));
  assign last_pair   = (tmr == WIN_W'(RESP_BITS - 1));
  assign pidx        = tmr[PI_W-1:0];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (host.start) state_nxt = SETTLE;
      SETTLE:  if (last_settle) state_nxt = COUNT;
      COUNT:   if (last_count)  state_nxt = COMPARE;
      COMPARE: if (last_pair)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ro_en  = '0;
    busy_o = 1'b0;
    done_o = 1'b0;
    accept = 1'b0;
    cnt_en = 1'b0;
    cmp_en = 1'b0;
    case (state)
      IDLE:    accept = host.start;
      SETTLE:  begin ro_en = '1; busy_o = 1'b1; end
      COUNT:   begin ro_en = '1; busy_o = 1'b1; cnt_en = 1'b1; end
      COMPARE: begin busy_o = 1'b1; cmp_en = 1'b1; end
      DONE:    begin busy_o = 1'b1; done_o = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)              tmr <= '0;
    else if (state_nxt != state) tmr <= '0;
    else if (state != IDLE)      tmr <= tmr + WIN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ch_q  <= '0;
      win_q <= WIN_W'(1);
    end else if (accept) begin
      ch_q  <= host.challenge;
      win_q <= (host.window_len == '0) ? WIN_W'(1) : host.window_len;
    end
  end

  // Unused address slots read as zero so out-of-range indices never select X.
  for (genvar j = 0; j < NSLOT; j++) begin : g_ch
    if (j < NUM_RO) begin : g_cnt
      ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_int_n),
        .ro_in  (ro_in[j]),
        .clr    (accept),
        .cnt_en (cnt_en),
        .cnt    (cnt_all[j])
      );
    end else begin : g_pad
      assign cnt_all[j] = '0;
    end
  end

  always_comb begin
    idx_a = '0;
    idx_b = '0;
    for (int i = 0; i < RESP_BITS; i++) begin
      if (pidx == PI_W'(i)) begin
        idx_a = ch_q[i*2*IDX_W +: IDX_W];
        idx_b = ch_q[i*2*IDX_W + IDX_W +: IDX_W];
      end
    end
    pair_inv = (idx_a == idx_b) || (int'(idx_a) >= NUM_RO) || (int'(idx_b) >= NUM_RO);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      resp_q <= '0;
      tie_q  <= '0;
      inv_q  <= '0;
    end else if (accept) begin
      resp_q <= '0;
      tie_q  <= '0;
      inv_q  <= '0;
    end else if (cmp_en) begin
      resp_q[pidx] <= ~pair_inv & (cnt_all[idx_a] >  cnt_all[idx_b]);
      tie_q[pidx]  <= ~pair_inv & (cnt_all[idx_a] == cnt_all[idx_b]);
      inv_q[pidx]  <= pair_inv;
    end
  end

  assign host.busy     = busy_o;
  assign host.done     = done_o;
  assign host.response = resp_q;
  assign host.tie      = tie_q;
  assign host.invalid  = inv_q;
endmodule
